gelato_l1_dcache: RTL and testbench

- Direct-mapped, write-through, one-word-per-line L1 data cache.
- Sits between the load/store unit and the L2 memory port. The LSU issues one word request at a time; the cache answers load hits locally and forwards load misses and all stores to L2.
- Serves one request at a time (blocking); no outstanding misses.

---
 rtl/gelato_l1_dcache_if.sv | 40 ++++
 rtl/gelato_l1_dcache.sv | 151 +++++++++++++++
 tb/tb_gelato_l1_dcache.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gelato_l1_dcache_if.sv
// rtl/gelato_l1_dcache_if.sv - LSU and L2 handshake bundle for the gelato L1 data cache
//
// Purpose: groups the LSU request/response signals and the L2 memory port
// signals of gelato_l1_dcache into one interface.
// Modports:
//   slave  - the cache side: takes LSU requests and L2 replies, drives LSU
//            responses and L2 requests.
//   master - the environment side (LSU plus L2 model), the mirror image.
// Signals:
//   lsu_valid/lsu_write/lsu_addr/lsu_wdata  LSU request (held until lsu_done)
//   lsu_done/lsu_rdata                      one-cycle completion and load data
//   mem_valid/mem_write/mem_addr/mem_wdata  L2 request (held until mem_done)
//   mem_done/mem_rdata                      L2 completion pulse and load data
interface gelato_l1_dcache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  lsu_valid;
  logic                  lsu_write;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic                  lsu_done;
  logic [DATA_WIDTH-1:0] lsu_rdata;
  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  lsu_valid, lsu_write, lsu_addr, lsu_wdata, mem_done, mem_rdata,
    output lsu_done, lsu_rdata, mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output lsu_valid, lsu_write, lsu_addr, lsu_wdata, mem_done, mem_rdata,
    input  lsu_done, lsu_rdata, mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gelato_l1_dcache.sv
// rtl/gelato_l1_dcache.sv - direct-mapped write-through one-word-per-line L1 data cache
//
// Purpose: answers LSU load hits locally; forwards load misses and all stores
// to L2. One request in flight at a time. Load misses allocate, store hits
// update the line, store misses do not allocate.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   rdy    - global enable; when low every register holds
//   flush  - invalidate all lines (honoured only in IDLE)
//   bus    - gelato_l1_dcache_if.slave: LSU request/response and L2 port
module gelato_l1_dcache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_NUM   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 flush,
  gelato_l1_dcache_if.slave    bus
);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_REQ  = 2'd2,
    WAIT_MEM = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LINE_NUM-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [LINE_NUM];
  logic [DATA_WIDTH-1:0] data_q [LINE_NUM];

  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;

  logic                  lsu_done_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic                  mem_valid_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             line_hit;
  logic             load_hit;
  logic             accept;

  assign req_idx  = req_addr_q[2 +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign load_hit = !req_write_q && line_hit;
  // lsu_done high means the LSU has not yet seen the completion and still
  // holds lsu_valid for the finished request, so it must not be re-accepted.
  assign accept   = !flush && bus.lsu_valid && !lsu_done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = LOOKUP;
      LOOKUP:   state_d = load_hit ? IDLE : WAIT_MEM;
      WAIT_MEM: if (bus.mem_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      lsu_done_q  <= 1'b0;
      lsu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (rdy) begin
      lsu_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (accept) begin
            req_write_q <= bus.lsu_write;
            req_addr_q  <= bus.lsu_addr;
            req_wdata_q <= bus.lsu_wdata;
          end
        end
        LOOKUP: begin
          if (load_hit) begin
            lsu_rdata_q <= data_q[req_idx];
            lsu_done_q  <= 1'b1;
          end else begin
            mem_valid_q <= 1'b1;
            mem_write_q <= req_write_q;
            mem_addr_q  <= {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_q <= req_wdata_q;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_done) begin
            mem_valid_q <= 1'b0;
            lsu_done_q  <= 1'b1;
            if (!req_write_q) begin
              valid_q[req_idx] <= 1'b1;
              lsu_rdata_q      <= bus.mem_rdata;
            end
          end
        end
        default: mem_valid_q <= 1'b0;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide a hit.
  // Writes happen only on L2 completion, which reset makes unreachable.
  always_ff @(posedge clk) begin
    if (rdy && (state_q == WAIT_MEM) && bus.mem_done) begin
      if (!req_write_q) begin
        tag_q[req_idx]  <= req_tag;
        data_q[req_idx] <= bus.mem_rdata;
      end else if (line_hit) begin
        data_q[req_idx] <= req_wdata_q;
      end
    end
  end

  assign bus.lsu_done  = lsu_done_q;
  assign bus.lsu_rdata = lsu_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_gelato_l1_dcache.sv
// tb/tb_gelato_l1_dcache.sv - self-checking bench for gelato_l1_dcache
module tb_gelato_l1_dcache;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;
  logic flush = 1'b0;

  gelato_l1_dcache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gelato_l1_dcache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_NUM(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  mem_exp_t      mem_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  // One LSU access with an L2 responder. Expected L2 request and load data go
  // into the scoreboard queues when the request is driven and are popped when
  // the DUT produces them.
  task automatic lsu_access(input string name, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic exp_miss,
                            input logic [DW-1:0] l2_rdata, input logic [DW-1:0] exp_rdata,
                            input int exp_lat, input logic with_flush);
    bit       mem_seen = 0;
    bit       done = 0;
    int       cyc = 0;
    mem_exp_t m;
    mem_exp_t e;
    logic [DW-1:0] r;
    if (exp_miss) begin
      m.write = wr;
      m.addr  = {addr[AW-1:2], 2'b00};
      m.data  = wdata;
      mem_q.push_back(m);
    end
    if (!wr) rd_q.push_back(exp_rdata);
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_write = wr;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
    flush         = with_flush;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      flush        = 1'b0;
      bus.mem_done = 1'b0;
      if (bus.mem_valid && !mem_seen) begin
        mem_seen = 1;
        n_cmp++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_mem_req: got addr=%h write=%b, required no L2 request", name, bus.mem_addr, bus.mem_write);
        end else begin
          e = mem_q.pop_front();
          if (bus.mem_write !== e.write || bus.mem_addr !== e.addr || (e.write && bus.mem_wdata !== e.data)) begin
            n_err++;
            $display("FAIL %s mem_req: got w=%b a=%h d=%h, required w=%b a=%h d=%h", name,
                     bus.mem_write, bus.mem_addr, bus.mem_wdata, e.write, e.addr, e.data);
          end
        end
        bus.mem_done  = 1'b1;
        bus.mem_rdata = l2_rdata;
      end
      if (bus.lsu_done) begin
        done = 1;
        bus.lsu_valid = 1'b0;
        if (!wr) begin
          r = rd_q.pop_front();
          n_cmp++;
          if (bus.lsu_rdata !== r) begin
            n_err++;
            $display("FAIL %s lsu_rdata: got %h, required %h", name, bus.lsu_rdata, r);
          end
        end
        if (exp_lat > 0) begin
          n_cmp++;
          if (cyc != exp_lat) begin
            n_err++;
            $display("FAIL %s hit_latency: got %0d, required %0d", name, cyc, exp_lat);
          end
        end
      end
    end
    bus.mem_done  = 1'b0;
    bus.lsu_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: got no lsu_done, required lsu_done within 60 cycles", name);
      if (!wr) void'(rd_q.pop_front());
    end
    if (exp_miss && !mem_seen) begin
      n_err++;
      $display("FAIL %s missing_mem_req: got none, required L2 request", name);
      void'(mem_q.pop_front());
    end
    @(negedge clk);
    n_cmp++;
    if (bus.lsu_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse: got lsu_done=%b, required 0", name, bus.lsu_done);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.lsu_done !== 1'b0 || bus.lsu_rdata !== '0 || bus.mem_valid !== 1'b0 ||
        bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got done=%b rd=%h mv=%b mw=%b ma=%h md=%h, required all 0",
               bus.lsu_done, bus.lsu_rdata, bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_valid !== 1'b0 || bus.lsu_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got mv=%b done=%b, required 0/0", bus.mem_valid, bus.lsu_done);
    end
  endtask

  task automatic test_load_miss;
    lsu_access("load_miss_40", 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
    lsu_access("load_miss_unaligned", 1'b0, 32'h47, 32'h0, 1'b1, 32'h0505_0505, 32'h0505_0505, 0, 1'b0);
  endtask

  task automatic test_load_hit;
    lsu_access("load_hit_40", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    lsu_access("load_hit_offset", 1'b0, 32'h42, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
  endtask

  task automatic test_store;
    lsu_access("store_hit_40", 1'b1, 32'h40, 32'h1234_5678, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    lsu_access("load_after_store", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 2, 1'b0);
    lsu_access("store_miss_80", 1'b1, 32'h80, 32'hAAAA_5555, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    lsu_access("load_after_store_miss", 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1'b0);
  endtask

  task automatic test_conflict;
    lsu_access("conflict_40", 1'b0, 32'h40, 32'h0, 1'b1, 32'h1111_1111, 32'h1111_1111, 0, 1'b0);
    lsu_access("conflict_80", 1'b0, 32'h80, 32'h0, 1'b1, 32'h2222_2222, 32'h2222_2222, 0, 1'b0);
    lsu_access("conflict_40_again", 1'b0, 32'h40, 32'h0, 1'b1, 32'h3333_3333, 32'h3333_3333, 0, 1'b0);
  endtask

  task automatic test_flush;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    lsu_access("load_after_flush", 1'b0, 32'h40, 32'h0, 1'b1, 32'h4444_4444, 32'h4444_4444, 0, 1'b0);
    lsu_access("hit_before_collide", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h4444_4444, 2, 1'b0);
    lsu_access("flush_with_valid", 1'b0, 32'h40, 32'h0, 1'b1, 32'h5555_5555, 32'h5555_5555, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vals[4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      lsu_access("b2b_fill", 1'b0, 32'h1000 + 32'(i * 4 + 16), 32'h0, 1'b1, vals[i], vals[i], 0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      lsu_access("b2b_hit", 1'b0, 32'h1000 + 32'(i * 4 + 16), 32'h0, 1'b0, 32'h0, vals[i], 2, 1'b0);
    end
  endtask

  task automatic test_rdy_freeze;
    int cyc = 0;
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_write = 1'b0;
    bus.lsu_addr  = 32'h1C8;
    while (!bus.mem_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (bus.mem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_setup: got mem_valid=%b, required 1", bus.mem_valid);
    end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_done  = (i == 1);
      bus.mem_rdata = 32'h9999_9999;
      @(negedge clk);
      n_cmp++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h1C8 || bus.mem_write !== 1'b0 || bus.lsu_done !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_hold: got mv=%b ma=%h mw=%b done=%b, required 1/000001c8/0/0",
                 bus.mem_valid, bus.mem_addr, bus.mem_write, bus.lsu_done);
      end
    end
    bus.mem_done = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_valid !== 1'b1 || bus.lsu_done !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_lost_done: got mv=%b done=%b, required 1/0", bus.mem_valid, bus.lsu_done);
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_done  = 1'b0;
    bus.lsu_valid = 1'b0;
    n_cmp++;
    if (bus.lsu_done !== 1'b1 || bus.lsu_rdata !== 32'hCAFE_F00D || bus.mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_complete: got done=%b rd=%h mv=%b, required 1/cafef00d/0",
               bus.lsu_done, bus.lsu_rdata, bus.mem_valid);
    end
    @(negedge clk);
    lsu_access("hit_after_freeze", 1'b0, 32'h1C8, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 1'b0);
  endtask

  task automatic test_reset_midop;
    int cyc = 0;
    lsu_access("midop_fill", 1'b0, 32'h30C, 32'h0, 1'b1, 32'h7777_0000, 32'h7777_0000, 0, 1'b0);
    lsu_access("midop_hit", 1'b0, 32'h30C, 32'h0, 1'b0, 32'h0, 32'h7777_0000, 2, 1'b0);
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_write = 1'b0;
    bus.lsu_addr  = 32'h184;
    while (!bus.mem_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_valid !== 1'b0 || bus.mem_addr !== '0 || bus.lsu_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midop: got mv=%b ma=%h done=%b, required 0/0/0",
               bus.mem_valid, bus.mem_addr, bus.lsu_done);
    end
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lsu_access("miss_after_reset", 1'b0, 32'h30C, 32'h0, 1'b1, 32'h8888_0000, 32'h8888_0000, 0, 1'b0);
  endtask

  initial begin
    bus.lsu_valid = 1'b0;
    bus.lsu_write = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store();
    test_conflict();
    test_flush();
    test_back_to_back();
    test_rdy_freeze();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
